uart_rx_fifo: RTL

- Sits directly downstream of the UART receiver. Consumes its data/ready pair and acknowledges each byte via the receiver's reset_ready input.
- Buffers received bytes in a synchronous FIFO so the consumer can drain them at its own pace.
- Flags overflow when bytes arrive while the FIFO is full.

---
 rtl/uart_rx_fifo_pkg.sv | 15 +
 rtl/uart_rx_fifo_sync_fifo.sv | 73 +++++++
 rtl/uart_rx_fifo.sv | 89 ++++++++
 3 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path constants.
//   DEFAULT_DATA_WIDTH : width of a received byte
//   DEFAULT_DEPTH_LOG2 : log2 of the receive FIFO depth
//   capture_state_t    : states of the receiver capture/acknowledge FSM
package uart_rx_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH_LOG2 = 4;

  typedef enum logic {
    sIdle = 1'b0,  // waiting for the receiver to flag a byte
    sAck  = 1'b1   // byte taken, acknowledging until rx_ready drops
  } capture_state_t;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous FIFO with registered read data.
//   clk, reset : clock and synchronous active-high reset
//   wr_en      : write wr_data this cycle (caller guarantees a free slot,
//                or a same-cycle read of a full FIFO)
//   rd_en      : read request; ignored while empty
//   rd_data    : registered read data, holds between reads
//   rd_valid   : one-cycle pulse, rd_data holds a new entry
//   empty/full : derived from the registered occupancy count
//   count      : current occupancy, 0 .. 2**DEPTH_LOG2
module sync_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int                DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_rd;

  // A read of an empty FIFO is dropped, so a write into an empty FIFO is
  // never visible on rd_data in the same cycle.
  assign do_rd = rd_en && !empty;
  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // NOTE: the storage array has no reset; only pointers and count define
  // which entries are meaningful, and a resettable RAM would not map to
  // memory macros.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_rd;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      unique case ({wr_en, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer sitting directly behind the UART receiver.
//   clk, reset      : clock shared with the receiver, sync active-high reset
//   rx_data/rx_ready: byte and level "byte available" flag from the receiver
//   rx_reset_ready  : registered acknowledge back to the receiver
//   rd_en           : consumer read request
//   rd_data/rd_valid: registered read data and its one-cycle valid pulse
//   empty/full/count: FIFO occupancy status
//   overflow        : sticky, a byte arrived while the FIFO was full
//   clear_overflow  : clears overflow (a same-cycle drop wins)
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_ready,
  output logic                  rx_reset_ready,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  clear_overflow
);

  capture_state_t state;
  logic           capture;
  logic           wr_accept;
  logic           drop;

  // One capture per rx_ready assertion: only the idle state samples the byte.
  assign capture   = (state == sIdle) && rx_ready;
  // A full FIFO is never empty, so rd_en alone guarantees the read that
  // frees the slot this write needs.
  assign wr_accept = capture && (!full || rd_en);
  assign drop      = capture && !wr_accept;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_accept),
    .wr_data  (rx_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (full),
    .count    (count)
  );

  // Dropped bytes are acknowledged like accepted ones so the receiver
  // never stalls waiting on a full buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= sIdle;
      rx_reset_ready <= 1'b0;
    end else begin
      unique case (state)
        sIdle: if (rx_ready) begin
          state          <= sAck;
          rx_reset_ready <= 1'b1;
        end
        sAck: if (!rx_ready) begin
          state          <= sIdle;
          rx_reset_ready <= 1'b0;
        end
        default: begin
          state          <= sIdle;
          rx_reset_ready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)               overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end

endmodule
